// File: rtl/alu_serial.sv
// rtl/alu_serial.sv - multi-cycle slice-serial ALU with start/done handshake
module alu_serial #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [2:0]       M,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] X,
    output logic             CO,
    output logic             Z
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_XNOR = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_next, x_q;
    logic [2:0]       m_q;
    logic             carry_q, co_q, z_q;
    logic [CW-1:0]    cnt_q;

    logic [SLICE-1:0] a_sl, b_sl, b_eff, res_sl;
    logic [SLICE:0]   sum_ext;
    logic             arith, last, accept;

    assign accept = (state_q != ST_RUN) && START;
    assign last   = (cnt_q == CW'(N - 1));
    assign arith  = (m_q == OP_ADD) || (m_q == OP_SUB);

    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: state_d = START ? ST_RUN : ST_IDLE;
            ST_RUN:           state_d = last ? ST_DONE : ST_RUN;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Slice datapath: SUB reuses the adder with inverted B and carry-in of 1.
    always_comb begin
        a_sl    = a_q[cnt_q * SLICE +: SLICE];
        b_sl    = b_q[cnt_q * SLICE +: SLICE];
        b_eff   = (m_q == OP_SUB) ? ~b_sl : b_sl;
        sum_ext = {1'b0, a_sl} + {1'b0, b_eff} + (SLICE + 1)'(carry_q);
        res_sl  = '0;
        case (m_q)
            OP_ADD, OP_SUB: res_sl = sum_ext[SLICE-1:0];
            OP_AND:         res_sl = a_sl & b_sl;
            OP_OR:          res_sl = a_sl | b_sl;
            OP_XOR:         res_sl = a_sl ^ b_sl;
            OP_XNOR:        res_sl = ~(a_sl ^ b_sl);
            default:        res_sl = '0;
        endcase
        acc_next = acc_q;
        acc_next[cnt_q * SLICE +: SLICE] = res_sl;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            co_q    <= 1'b0;
            z_q     <= 1'b0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= B;
            m_q     <= M;
            carry_q <= (M == OP_SUB);
            cnt_q   <= '0;
            acc_q   <= '0;
        end else if (state_q == ST_RUN) begin
            acc_q   <= acc_next;
            carry_q <= arith ? sum_ext[SLICE] : 1'b0;
            if (last) begin
                x_q  <= acc_next;
                co_q <= arith ? sum_ext[SLICE] : 1'b0;
                z_q  <= (acc_next == '0);
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign BUSY = (state_q == ST_RUN);
    assign DONE = (state_q == ST_DONE);
    assign X    = x_q;
    assign CO   = co_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_alu_serial.sv
// tb/tb_alu_serial.sv - directed self-checking bench for alu_serial
module tb_alu_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, start16;
    logic [2:0]  m8, m16;
    logic [7:0]  a8, b8, x8;
    logic [15:0] a16, b16, x16;
    logic        busy8, done8, co8, z8;
    logic        busy16, done16, co16, z16;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(8), .SLICE(1)) dut8 (
        .CLK(clk), .RST_N(rst_n), .START(start8), .M(m8), .A(a8), .B(b8),
        .BUSY(busy8), .DONE(done8), .X(x8), .CO(co8), .Z(z8)
    );

    alu_serial #(.WIDTH(16), .SLICE(4)) dut16 (
        .CLK(clk), .RST_N(rst_n), .START(start16), .M(m16), .A(a16), .B(b16),
        .BUSY(busy16), .DONE(done16), .X(x16), .CO(co16), .Z(z16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Waits (bounded) for DONE on the 8-bit unit; lat = edges after the accept edge.
    task automatic wait_done8(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!done8 && lat < 40) begin
            if (busy8) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic run8(input string tag, input logic [2:0] m, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] ex, input logic eco,
                        input logic ez);
        int lat, bc;
        m8 = m; a8 = a; b8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = ~a; b8 = ~b;
        wait_done8(lat, bc);
        chk({tag, "_lat"},  lat, 8);
        chk({tag, "_busy"}, bc, 8);
        chk({tag, "_x"},    x8, ex);
        chk({tag, "_co"},   co8, eco);
        chk({tag, "_z"},    z8, ez);
        chk({tag, "_bsy0"}, busy8, 1'b0);
        tick();
        chk({tag, "_pulse"}, done8, 1'b0);
    endtask

    initial begin
        int lat, bc, ndone, gap;
        rst_n = 1'b0;
        start8 = 1'b0; m8 = '0; a8 = '0; b8 = '0;
        start16 = 1'b0; m16 = '0; a16 = '0; b16 = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_x",    x8, 8'h00);
        chk("rst_co",   co8, 1'b0);
        chk("rst_z",    z8, 1'b0);
        chk("rst_x16",  x16, 16'h0000);

        run8("add_ff01", 3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
        run8("sub_5m7",  3'd5, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
        run8("sub_7m5",  3'd5, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0);
        run8("xnor",     3'd4, 8'hF0, 8'hCC, 8'hC3, 1'b0, 1'b0);
        run8("and",      3'd1, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1);
        run8("or",       3'd2, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0);
        run8("xor",      3'd3, 8'h5A, 8'hFF, 8'hA5, 1'b0, 1'b0);
        run8("rsv6",     3'd6, 8'hAB, 8'hCD, 8'h00, 1'b0, 1'b1);
        run8("rsv7",     3'd7, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);

        // START during RUN must be ignored
        m8 = 3'd0; a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        chk("ign_prev_x", x8, 8'h00);
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8(lat, bc);
        chk("ign_lat", lat + 3, 8);
        chk("ign_x",   x8, 8'h30);
        chk("ign_co",  co8, 1'b0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) ndone++;
        end
        chk("ign_nodone", ndone, 0);

        // START held high: back-to-back operations
        m8 = 3'd0; a8 = 8'h03; b8 = 8'h04; start8 = 1'b1;
        tick();
        wait_done8(lat, bc);
        chk("b2b_lat1", lat, 8);
        chk("b2b_x1",   x8, 8'h07);
        gap = 0;
        tick();
        gap++;
        while (!done8 && gap < 40) begin
            tick();
            gap++;
        end
        chk("b2b_gap", gap, 9);
        chk("b2b_x2",  x8, 8'h07);
        start8 = 1'b0;
        tick();
        tick();

        // Reset mid-RUN aborts the operation
        m8 = 3'd0; a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", busy8, 1'b0);
        chk("abort_x",    x8, 8'h00);
        chk("abort_co",   co8, 1'b0);
        chk("abort_z",    z8, 1'b0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) ndone++;
            tick();
        end
        chk("abort_nodone", ndone, 0);

        // 16-bit, 4-bit slices
        m16 = 3'd0; a16 = 16'h8FFF; b16 = 16'h8001; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        chk("w16_busy", busy16, 1'b1);
        lat = 0;
        while (!done16 && lat < 40) begin
            tick();
            lat++;
        end
        chk("w16_lat", lat, 4);
        chk("w16_x",   x16, 16'h1000);
        chk("w16_co",  co16, 1'b1);
        chk("w16_z",   z16, 1'b0);

        m16 = 3'd5; a16 = 16'h1234; b16 = 16'h1234; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 40) begin
            tick();
            lat++;
        end
        chk("w16s_lat", lat, 4);
        chk("w16s_x",   x16, 16'h0000);
        chk("w16s_co",  co16, 1'b1);
        chk("w16s_z",   z16, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
